vector_mem_unit: RTL and testbench
==================================

Name: vector_mem_unit

Overview:
- Multi-cycle VLD/VST engine: moves one 256-bit vector (16 x 16-bit elements) between the vector datapath and the 16-bit-wide data memory.
- Sits behind the ALU. The ALU supplies the effective base address (op_1 + op_2). This block sequences 16 element accesses, then assembles the loaded vector or scatters the stored one.
- Pipeline control stalls on busy and resumes on done.

Parameters:
- ADDR_W, 16, memory address width; address arithmetic is modulo 2^ADDR_W.
- ELEM_W, 16, element and memory data width.
- NUM_ELEM, 16, elements per vector; vector width = NUM_ELEM*ELEM_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- op_store  in  1  1 = VST (write memory), 0 = VLD (read memory); latched with start.
- base_addr  in  ADDR_W  effective address from ALU; latched with start.
- wdata_vec  in  NUM_ELEM*ELEM_W  vector to store; latched with start.
- busy  out  1  high in ACCESS and DONE.
- done  out  1  one-cycle completion pulse.
- rdata_vec  out  NUM_ELEM*ELEM_W  last loaded vector.
- mem_addr  out  ADDR_W  element address.
- mem_wdata  out  ELEM_W  store data.
- mem_we  out  1  write strobe.
- mem_re  out  1  read strobe.
- mem_rdata  in  ELEM_W  read data; valid when mem_ready is high and mem_re is high.
- mem_ready  in  1  memory completes the current access this cycle.

Behaviour:
- Reset (async, rst_n low): state=IDLE, idx=0; busy, done, mem_we, mem_re = 0; mem_addr, mem_wdata, rdata_vec = 0. Reset mid-operation aborts immediately, no further strobes; partially loaded data is discarded.
- Element mapping: element i is bits [16i+15:16i], at address base+i (mod 2^16). Wrap from 0xFFFF to 0x0000 is silent.
- FSM states: IDLE, ACCESS, DONE.
- IDLE: on start=1, latch op_store, base_addr and wdata_vec; set idx=0; next state ACCESS. start is ignored in any other state (no queueing).
- ACCESS, outputs registered from state: mem_addr = base+idx; exactly one of mem_re/mem_we high; for store, mem_wdata = element idx of the latched vector.
- ACCESS, on mem_ready=1:
  - For load, capture mem_rdata into an internal element idx.
  - If idx == NUM_ELEM-1, go to DONE; otherwise idx++.
- ACCESS, on mem_ready=0: hold all outputs (wait states, unbounded).
- DONE: done=1 for exactly one cycle; strobes low. For load, rdata_vec updates with the full assembled vector on entry to DONE. Next state IDLE.
- rdata_vec changes only on completed loads; it is unchanged by stores and by aborted loads.
- Latency with mem_ready tied high: start sampled at edge 0; accesses on cycles 1..16; done high in cycle 17; a new start is accepted in cycle 18.
- Memory outputs are low/zero in IDLE and DONE.

Optional Feature:
- Macro: VMEM_STRIDE_EN.
- When defined: adds input port stride (ADDR_W), latched with start. Element address = base + idx*stride, truncated mod 2^ADDR_W. stride=0 accesses the same address 16 times.
- When not defined: no stride port; stride fixed at 1. Behaviour as above.

Test Plan:
- Load, mem_ready=1, base=0x0100, memory[0x100+i]=0xA000+i -> strobes on cycles 1..16, done in cycle 17, rdata_vec element i = 0xA000+i.
- Store, mem_ready toggling 1/0 each cycle, wdata element i=0x5A00+i -> exactly 16 writes, addresses 0x0200..0x020F in order, data matches, done once, rdata_vec unchanged.
- Wrap, load at base=0xFFF8 -> addresses 0xFFF8..0xFFFF then 0x0000..0x0007.
- start pulsed in ACCESS and DONE -> ignored; exactly one done per accepted start.
- rst_n low after 5 load elements -> all outputs 0 immediately, rdata_vec=0; a subsequent full load completes normally.
- With VMEM_STRIDE_EN, base=0x0010, stride=4 -> addresses 0x0010, 0x0014, ..., 0x004C; with stride=0 -> 16 accesses to 0x0010.

Source files
------------

// File: rtl/vector_mem_unit.sv
// Multi-cycle vector load/store engine: sequences NUM_ELEM element accesses to a narrow data memory.
// Optional build macro VMEM_STRIDE_EN adds a stride input (element address = base + idx*stride).
module vector_mem_unit #(
  parameter int ADDR_W   = 16,
  parameter int ELEM_W   = 16,
  parameter int NUM_ELEM = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       op_store,
  input  logic [ADDR_W-1:0]          base_addr,
`ifdef VMEM_STRIDE_EN
  input  logic [ADDR_W-1:0]          stride,
`endif
  input  logic [NUM_ELEM*ELEM_W-1:0] wdata_vec,
  output logic                       busy,
  output logic                       done,
  output logic [NUM_ELEM*ELEM_W-1:0] rdata_vec,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [ELEM_W-1:0]          mem_wdata,
  output logic                       mem_we,
  output logic                       mem_re,
  input  logic [ELEM_W-1:0]          mem_rdata,
  input  logic                       mem_ready
);

  localparam int VEC_W = NUM_ELEM * ELEM_W;
  localparam int IDX_W = $clog2(NUM_ELEM);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state_r;
  logic [IDX_W-1:0]  idx_r;
  logic              op_store_r;
  logic [ADDR_W-1:0] base_r;
  logic [VEC_W-1:0]  wdata_r;
  logic [VEC_W-1:0]  load_buf_r;

  logic [ADDR_W-1:0] stride_s;
  logic [IDX_W-1:0]  next_idx_s;
  logic [ADDR_W-1:0] next_addr_s;
  logic [ELEM_W-1:0] next_wdata_s;
  logic [VEC_W-1:0]  load_next_s;

`ifdef VMEM_STRIDE_EN
  logic [ADDR_W-1:0] stride_r;
  assign stride_s = stride_r;
`else
  assign stride_s = ADDR_W'(1);
`endif

  // Next element address/data, and the load buffer with the element arriving this cycle merged in
  always_comb begin
    next_idx_s   = idx_r + IDX_W'(1);
    next_addr_s  = base_r + ADDR_W'(next_idx_s) * stride_s;
    next_wdata_s = wdata_r[next_idx_s*ELEM_W +: ELEM_W];
    load_next_s  = load_buf_r;
    load_next_s[idx_r*ELEM_W +: ELEM_W] = mem_rdata;
  end

  // Control FSM with all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      idx_r      <= {IDX_W{1'b0}};
      op_store_r <= 1'b0;
      base_r     <= {ADDR_W{1'b0}};
      wdata_r    <= {VEC_W{1'b0}};
      load_buf_r <= {VEC_W{1'b0}};
`ifdef VMEM_STRIDE_EN
      stride_r   <= {ADDR_W{1'b0}};
`endif
      busy       <= 1'b0;
      done       <= 1'b0;
      rdata_vec  <= {VEC_W{1'b0}};
      mem_addr   <= {ADDR_W{1'b0}};
      mem_wdata  <= {ELEM_W{1'b0}};
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state_r    <= ACCESS;
            idx_r      <= {IDX_W{1'b0}};
            op_store_r <= op_store;
            base_r     <= base_addr;
            wdata_r    <= wdata_vec;
`ifdef VMEM_STRIDE_EN
            stride_r   <= stride;
`endif
            busy       <= 1'b1;
            mem_addr   <= base_addr;
            mem_we     <= op_store;
            mem_re     <= ~op_store;
            mem_wdata  <= op_store ? wdata_vec[ELEM_W-1:0] : {ELEM_W{1'b0}};
          end else begin
            busy <= 1'b0;
          end
        end
        ACCESS: begin
          // Without mem_ready every output simply holds (wait state)
          if (mem_ready) begin
            if (!op_store_r) begin
              load_buf_r <= load_next_s;
            end else begin
              load_buf_r <= load_buf_r;
            end
            if (idx_r == IDX_W'(NUM_ELEM-1)) begin
              state_r   <= DONE;
              done      <= 1'b1;
              mem_we    <= 1'b0;
              mem_re    <= 1'b0;
              mem_addr  <= {ADDR_W{1'b0}};
              mem_wdata <= {ELEM_W{1'b0}};
              if (!op_store_r) begin
                rdata_vec <= load_next_s;
              end else begin
                rdata_vec <= rdata_vec;
              end
            end else begin
              idx_r     <= next_idx_s;
              mem_addr  <= next_addr_s;
              mem_wdata <= op_store_r ? next_wdata_s : {ELEM_W{1'b0}};
            end
          end else begin
            idx_r <= idx_r;
          end
        end
        DONE: begin
          state_r <= IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state_r   <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
          mem_we    <= 1'b0;
          mem_re    <= 1'b0;
          mem_addr  <= {ADDR_W{1'b0}};
          mem_wdata <= {ELEM_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_mem_unit.sv
// Scoreboard bench for vector_mem_unit: stimulus pushes expected accesses/completions, a negedge monitor checks them.
module tb_vector_mem_unit;
  localparam int AW = 16;
  localparam int EW = 16;
  localparam int NE = 16;
  localparam int VW = NE * EW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          op_store = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] stride = 16'd1;
  logic [VW-1:0] wdata_vec = '0;
  logic          busy, done, mem_we, mem_re;
  logic [VW-1:0] rdata_vec;
  logic [AW-1:0] mem_addr;
  logic [EW-1:0] mem_wdata, mem_rdata;
  logic          mem_ready = 1'b1;

  logic [EW-1:0] mem     [0:65535];
  logic [EW-1:0] ref_mem [0:65535];

  typedef struct {
    bit            we;
    logic [AW-1:0] addr;
    logic [EW-1:0] data;
  } acc_t;

  acc_t          acc_q[$];
  logic [VW-1:0] cmp_q[$];
  logic [VW-1:0] last_rdata = '0;
  int checks = 0, errors = 0;
  int cyc = 0, done_cnt = 0, done_cyc = 0, acc_done = 0, accepted = 0;
  int ready_mode = 0;

  vector_mem_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_store(op_store), .base_addr(base_addr),
`ifdef VMEM_STRIDE_EN
    .stride(stride),
`endif
    .wdata_vec(wdata_vec), .busy(busy), .done(done), .rdata_vec(rdata_vec),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (rst_n && mem_we && mem_ready) mem[mem_addr] <= mem_wdata;

  task automatic check(input bit ok, input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: element i lives at base + i*stride; a load returns the vector, a store updates memory.
  task automatic push_expect(input bit st, input logic [AW-1:0] base, input logic [VW-1:0] wv);
    acc_t e;
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < NE; i++) begin
      e.we   = st;
      e.addr = base + 16'(i) * stride;
      e.data = wv[i*EW +: EW];
      acc_q.push_back(e);
      if (st) ref_mem[e.addr] = e.data;
      else    v[i*EW +: EW] = ref_mem[e.addr];
    end
    if (!st) last_rdata = v;
    cmp_q.push_back(last_rdata);
  endtask

  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      0:       mem_ready = 1'b1;
      1:       mem_ready = ~mem_ready;
      2:       mem_ready = 1'($urandom % 2);
      default: mem_ready = 1'b1;
    endcase
  end

  // Monitor: checks strobes against the expected access stream and each done against the expected vector
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_re || mem_we) begin
        if (acc_q.size() == 0) begin
          check(1'b0, "stray_strobe", VW'(mem_addr), '0);
        end else begin
          check(!(mem_re && mem_we) && mem_we == acc_q[0].we && mem_re == !acc_q[0].we &&
                mem_addr == acc_q[0].addr && (!acc_q[0].we || mem_wdata == acc_q[0].data),
                "access", {mem_we, mem_re, mem_addr, mem_wdata}, {acc_q[0].we, !acc_q[0].we, acc_q[0].addr, acc_q[0].data});
          if (mem_ready) begin
            void'(acc_q.pop_front());
            acc_done++;
          end
        end
      end else begin
        check(mem_addr == '0 && mem_wdata == '0, "idle_mem_outputs", {mem_addr, mem_wdata}, '0);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (cmp_q.size() == 0) begin
          check(1'b0, "spurious_done", VW'(done_cnt), '0);
        end else begin
          check(rdata_vec == cmp_q[0], "rdata_vec", rdata_vec, cmp_q[0]);
          check(busy && acc_q.size() == 0, "done_state", {busy, 32'(acc_q.size())}, {1'b1, 32'd0});
          void'(cmp_q.pop_front());
        end
      end
    end
  end

  task automatic run_op(input bit st, input logic [AW-1:0] base, input logic [VW-1:0] wv, input int mode, input bit poke);
    int n, target, s_cyc;
    @(posedge clk); #1;
    n = 0;
    while (busy && n < 50) begin @(posedge clk); #1; n++; end
    check(n < 50, "idle_timeout", VW'(n), '0);
    ready_mode = mode;
    op_store = st; base_addr = base; wdata_vec = wv; start = 1'b1;
    push_expect(st, base, wv);
    accepted++;
    target = done_cnt + 1;
    s_cyc = cyc;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
      if (poke) begin
        start = 1'b1; op_store = 1'($urandom % 2); base_addr = 16'($urandom);
        wdata_vec = {8{$urandom}};
      end else begin
        start = 1'b0;
      end
    end while (done_cnt < target && n < 400);
    start = 1'b0;
    check(done_cnt == target, "done_timeout", VW'(done_cnt), VW'(target));
    if (mode == 0) check(done_cyc - s_cyc == 17, "latency", VW'(done_cyc - s_cyc), VW'(17));
  endtask

  initial begin
    logic [VW-1:0] v;
    int n, target;
    for (int a = 0; a < 65536; a++) begin
      mem[a] = 16'($urandom);
      ref_mem[a] = mem[a];
    end
    for (int i = 0; i < NE; i++) begin
      mem[16'h0100 + i] = 16'hA000 + 16'(i);
      ref_mem[16'h0100 + i] = 16'hA000 + 16'(i);
    end
    #22;
    check({busy, done, mem_we, mem_re, mem_addr, mem_wdata} == '0 && rdata_vec == '0, "reset_state",
          {busy, done, mem_we, mem_re, mem_addr, mem_wdata}, '0);
    rst_n = 1'b1;

    run_op(1'b0, 16'h0100, '0, 0, 1'b0);
    for (int i = 0; i < NE; i++) v[i*EW +: EW] = 16'h5A00 + 16'(i);
    run_op(1'b1, 16'h0200, v, 1, 1'b0);
    run_op(1'b0, 16'h0200, '0, 0, 1'b0);
    run_op(1'b0, 16'hFFF8, '0, 0, 1'b0);
    run_op(1'b0, 16'h0100, '0, 0, 1'b1);
    run_op(1'b1, 16'h1234, {8{32'hC0DE_F00D}}, 2, 1'b1);

    // Abort a load after five completed elements
    @(posedge clk); #1;
    ready_mode = 0; op_store = 1'b0; base_addr = 16'h0300; start = 1'b1;
    push_expect(1'b0, 16'h0300, '0);
    target = acc_done + 5;
    @(posedge clk); #1; start = 1'b0;
    n = 0;
    while (acc_done < target && n < 100) begin @(posedge clk); #1; n++; end
    check(n < 100, "abort_timeout", VW'(n), '0);
    #2 rst_n = 1'b0;
    #1;
    check({busy, done, mem_we, mem_re, mem_addr, mem_wdata} == '0, "abort_outputs",
          {busy, done, mem_we, mem_re, mem_addr, mem_wdata}, '0);
    check(rdata_vec == '0, "abort_rdata", rdata_vec, '0);
    acc_q.delete(); cmp_q.delete(); last_rdata = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_op(1'b0, 16'h0300, '0, 0, 1'b0);

`ifdef VMEM_STRIDE_EN
    stride = 16'd4;
    run_op(1'b0, 16'h0010, '0, 0, 1'b0);
    stride = 16'd0;
    run_op(1'b0, 16'h0010, '0, 1, 1'b0);
    run_op(1'b1, 16'h0010, {8{$urandom}}, 0, 1'b0);
`endif

    for (int k = 0; k < 25; k++) begin
`ifdef VMEM_STRIDE_EN
      stride = 16'($urandom_range(0, 9));
`endif
      run_op(1'($urandom % 2), 16'($urandom), {8{$urandom}}, $urandom_range(0, 2), ($urandom % 4) == 0);
    end

    repeat (4) @(posedge clk);
    #1;
    check(acc_q.size() == 0, "acc_queue_empty", VW'(acc_q.size()), '0);
    check(cmp_q.size() == 0, "cmp_queue_empty", VW'(cmp_q.size()), '0);
    check(done_cnt == accepted, "done_count", VW'(done_cnt), VW'(accepted));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
